// File: rtl/fxp32_pkg.sv
// Shared fixed-point datapath constants and pipeline payload types.
package fxp32_pkg;
  localparam int unsigned FXP32_WIDTH  = 32;
  localparam int unsigned FXP32_GROUPS = FXP32_WIDTH / 2;
  localparam logic [FXP32_WIDTH-1:0] FXP32_MAX = 32'h7FFF_FFFF;
  localparam logic [FXP32_WIDTH-1:0] FXP32_MIN = 32'h8000_0000;

  typedef struct packed {
    logic [FXP32_WIDTH-1:0]  a;
    logic [FXP32_WIDTH-1:0]  bi;
    logic                    cin;
    logic                    sa;
    logic                    sb;
    logic [FXP32_GROUPS-1:0] g;
    logic [FXP32_GROUPS-1:0] p;
  } s1_beat_t;

  typedef struct packed {
    logic [FXP32_WIDTH-1:0] d;
    logic                   borrow;
    logic                   ovf;
  } s2_beat_t;
endpackage

// File: rtl/cla_gen_prop.sv
// Merge a high and a low generate/propagate pair into one span.
module cla_gen_prop (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/fxp32_sub_carry.sv
// 16-group parallel-prefix carry lookahead: carry into each 2-bit group plus carry-out.
module fxp32_sub_carry
  import fxp32_pkg::*;
(
  input  logic [FXP32_GROUPS-1:0] g,
  input  logic [FXP32_GROUPS-1:0] p,
  input  logic                    cin,
  output logic [FXP32_GROUPS-1:0] cry,
  output logic                    cout
);
  localparam int unsigned LVLS = 4;

  logic [LVLS:0][FXP32_GROUPS-1:0] gl;
  logic [LVLS:0][FXP32_GROUPS-1:0] pl;

  assign gl[0] = g;
  assign pl[0] = p;

  // Kogge-Stone prefix: after level l each slot spans 2^(l+1) groups ending at it.
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    for (genvar i = 0; i < FXP32_GROUPS; i++) begin : g_col
      if (i >= (1 << l)) begin : g_merge
        cla_gen_prop u_gp (
          .g_hi (gl[l][i]),
          .p_hi (pl[l][i]),
          .g_lo (gl[l][i-(1<<l)]),
          .p_lo (pl[l][i-(1<<l)]),
          .g    (gl[l+1][i]),
          .p    (pl[l+1][i])
        );
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  assign cry[0] = cin;
  for (genvar i = 1; i < FXP32_GROUPS; i++) begin : g_cry
    assign cry[i] = gl[LVLS][i-1] | (pl[LVLS][i-1] & cin);
  end
  assign cout = gl[LVLS][FXP32_GROUPS-1] | (pl[LVLS][FXP32_GROUPS-1] & cin);
endmodule

// File: rtl/rca.sv
// Two-bit ripple-carry adder cell.
module rca (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);
  logic c1;
  assign s[0] = a[0] ^ b[0] ^ cin;
  assign c1   = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  assign s[1] = a[1] ^ b[1] ^ c1;
  assign cout = (a[1] & b[1]) | ((a[1] ^ b[1]) & c1);
endmodule

// File: rtl/fxp32_sub_pipe.sv
// Two-stage valid/ready 32-bit subtractor with borrow, signed overflow and optional saturation.
module fxp32_sub_pipe
  import fxp32_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FXP32_WIDTH-1:0] in_a,
  input  logic [FXP32_WIDTH-1:0] in_b,
  input  logic                   in_borrow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP32_WIDTH-1:0] out_d,
  output logic                   out_borrow,
  output logic                   out_overflow
);
  logic [FXP32_WIDTH-1:0]  bi_c, gen_c, prop_c, raw_c;
  logic [FXP32_GROUPS-1:0] grp_g_c, grp_p_c, cry_c, rca_co;
  logic                    cout_c, ovf_c, s2_adv, s1_adv, accept;
  logic                    s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  s1_beat_t                s1_q, s1_d;
  s2_beat_t                s2_q, s2_d;
  logic                    unused_rca_co;

  assign bi_c   = ~in_b;
  assign gen_c  = in_a & bi_c;
  assign prop_c = in_a ^ bi_c;

  for (genvar i = 0; i < FXP32_GROUPS; i++) begin : g_grp
    cla_gen_prop u_gp (
      .g_hi (gen_c[2*i+1]),
      .p_hi (prop_c[2*i+1]),
      .g_lo (gen_c[2*i]),
      .p_lo (prop_c[2*i]),
      .g    (grp_g_c[i]),
      .p    (grp_p_c[i])
    );
  end

  fxp32_sub_carry u_carry (
    .g    (s1_q.g),
    .p    (s1_q.p),
    .cin  (s1_q.cin),
    .cry  (cry_c),
    .cout (cout_c)
  );

  // Final carry comes from the lookahead tree; the per-group ripple carries are redundant.
  for (genvar i = 0; i < FXP32_GROUPS; i++) begin : g_rca
    rca u_rca (
      .a    (s1_q.a[2*i+1 -: 2]),
      .b    (s1_q.bi[2*i+1 -: 2]),
      .cin  (cry_c[i]),
      .s    (raw_c[2*i+1 -: 2]),
      .cout (rca_co[i])
    );
  end
  assign unused_rca_co = ^rca_co;

  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_ready    = rstn && s1_adv;
    accept      = in_valid && in_ready;
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    s2_d        = s2_q;
    out_valid_d = out_valid_q;
    ovf_c       = (s1_q.sa ^ s1_q.sb) & (raw_c[FXP32_WIDTH-1] ^ s1_q.sa);

    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_d.a   = in_a;
      s1_d.bi  = bi_c;
      s1_d.cin = ~in_borrow;
      s1_d.sa  = in_a[FXP32_WIDTH-1];
      s1_d.sb  = in_b[FXP32_WIDTH-1];
      s1_d.g   = grp_g_c;
      s1_d.p   = grp_p_c;
    end

    if (s2_adv) out_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_d.borrow = ~cout_c;
      s2_d.ovf    = ovf_c;
      if (SATURATE && ovf_c) s2_d.d = s1_q.sa ? FXP32_MIN : FXP32_MAX;
      else                   s2_d.d = raw_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_d        = s2_q.d;
  assign out_borrow   = s2_q.borrow;
  assign out_overflow = s2_q.ovf;
endmodule
